// File: rtl/remote_load_latency_stats_if.sv
// Launch/return event and stat-read bundle between the core's network_tx side and the latency stats block.
interface remote_load_latency_stats_if #(
    parameter int unsigned reg_els_p   = 32,
    parameter int unsigned sum_width_p = 48
);
    localparam int unsigned reg_id_w_lp = $clog2(reg_els_p);

    logic                   launch_v_i;
    logic [1:0]             launch_type_i;
    logic [reg_id_w_lp-1:0] launch_reg_id_i;
    logic                   ret_v_i;
    logic [1:0]             ret_type_i;
    logic [reg_id_w_lp-1:0] ret_reg_id_i;
    logic                   rd_v_i;
    logic [1:0]             rd_type_i;
    logic [4:0]             rd_field_i;
    logic                   rd_v_o;
    logic [sum_width_p-1:0] rd_data_o;

    modport master (
        output launch_v_i, launch_type_i, launch_reg_id_i,
        output ret_v_i, ret_type_i, ret_reg_id_i,
        output rd_v_i, rd_type_i, rd_field_i,
        input  rd_v_o, rd_data_o
    );

    modport slave (
        input  launch_v_i, launch_type_i, launch_reg_id_i,
        input  ret_v_i, ret_type_i, ret_reg_id_i,
        input  rd_v_i, rd_type_i, rd_field_i,
        output rd_v_o, rd_data_o
    );
endinterface

// File: rtl/remote_load_latency_stats.sv
// Per-tile remote-load latency profiler: timestamps int/float/icache loads at launch and
// accumulates count, saturating sum, max and a log2 histogram per type on return.
module remote_load_latency_stats #(
    parameter int unsigned reg_els_p   = 32,
    parameter int unsigned ctr_width_p = 32,
    parameter int unsigned sum_width_p = 48,
    parameter int unsigned hist_bins_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic [ctr_width_p-1:0] global_ctr_i,
    remote_load_latency_stats_if.slave bus
);
    localparam int unsigned reg_id_w_lp  = $clog2(reg_els_p);
    localparam int unsigned num_ent_lp   = 2 * reg_els_p + 1;
    localparam int unsigned ent_w_lp     = $clog2(num_ent_lp);
    localparam int unsigned bin_w_lp     = $clog2(hist_bins_p);
    localparam int unsigned sum_ext_w_lp = sum_width_p + 1;
    localparam int unsigned num_types_lp = 3;

    // Pending table: int regs, then float regs, then the single icache entry
    logic [num_ent_lp-1:0]  valid_q, valid_d;
    logic [ctr_width_p-1:0] start_q [num_ent_lp];
    logic [ctr_width_p-1:0] start_d [num_ent_lp];

    logic                   s1_v_q, s1_v_d;
    logic [1:0]             s1_type_q, s1_type_d;
    logic [ctr_width_p-1:0] s1_lat_q, s1_lat_d;

    logic [ctr_width_p-1:0] count_q  [num_types_lp];
    logic [ctr_width_p-1:0] count_d  [num_types_lp];
    logic [sum_width_p-1:0] sum_q    [num_types_lp];
    logic [sum_width_p-1:0] sum_d    [num_types_lp];
    logic [ctr_width_p-1:0] max_q    [num_types_lp];
    logic [ctr_width_p-1:0] max_d    [num_types_lp];
    logic [ctr_width_p-1:0] orphan_q [num_types_lp];
    logic [ctr_width_p-1:0] orphan_d [num_types_lp];
    logic [ctr_width_p-1:0] ovw_q    [num_types_lp];
    logic [ctr_width_p-1:0] ovw_d    [num_types_lp];
    logic [ctr_width_p-1:0] hist_q   [num_types_lp][hist_bins_p];
    logic [ctr_width_p-1:0] hist_d   [num_types_lp][hist_bins_p];

    logic                   rd_v_q, rd_v_d;
    logic [sum_width_p-1:0] rd_data_q, rd_data_d;

    logic                    launch_hit, ret_hit;
    logic [ent_w_lp-1:0]     launch_idx, ret_idx;
    logic [sum_ext_w_lp-1:0] sum_ext;
    logic [bin_w_lp-1:0]     s1_bin, rd_bin;
    logic [ctr_width_p-1:0]  outstanding;

    function automatic logic [ent_w_lp-1:0] ent_idx(input logic [1:0] t,
                                                    input logic [reg_id_w_lp-1:0] r);
        case (t)
            2'd0:    return ent_w_lp'(r);
            2'd1:    return ent_w_lp'(reg_els_p) + ent_w_lp'(r);
            default: return ent_w_lp'(2 * reg_els_p);
        endcase
    endfunction

    function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    // Histogram bin = index of the highest set bit, clamped to the last bin
    function automatic logic [bin_w_lp-1:0] lat_bin(input logic [ctr_width_p-1:0] lat);
        int b;
        b = 0;
        for (int i = 0; i < int'(ctr_width_p); i++) begin
            if (lat[i]) b = i;
        end
        if (b > int'(hist_bins_p) - 1) b = int'(hist_bins_p) - 1;
        return bin_w_lp'(b);
    endfunction

    // Pending-table, stage-1 and stats next state
    always_comb begin
        valid_d   = valid_q;
        start_d   = start_q;
        s1_v_d    = 1'b0;
        s1_type_d = s1_type_q;
        s1_lat_d  = s1_lat_q;
        count_d   = count_q;
        sum_d     = sum_q;
        max_d     = max_q;
        orphan_d  = orphan_q;
        ovw_d     = ovw_q;
        hist_d    = hist_q;
        sum_ext   = '0;

        launch_hit = en_i && bus.launch_v_i && (bus.launch_type_i != 2'd3);
        ret_hit    = en_i && bus.ret_v_i && (bus.ret_type_i != 2'd3);
        launch_idx = ent_idx(bus.launch_type_i, bus.launch_reg_id_i);
        ret_idx    = ent_idx(bus.ret_type_i, bus.ret_reg_id_i);
        s1_bin     = lat_bin(s1_lat_q);

        if (s1_v_q) begin
            count_d[s1_type_q] = sat_inc(count_q[s1_type_q]);
            sum_ext = sum_ext_w_lp'(sum_q[s1_type_q]) + sum_ext_w_lp'(s1_lat_q);
            sum_d[s1_type_q] = sum_ext[sum_width_p] ? '1 : sum_ext[sum_width_p-1:0];
            if (s1_lat_q > max_q[s1_type_q]) max_d[s1_type_q] = s1_lat_q;
            hist_d[s1_type_q][s1_bin] = sat_inc(hist_q[s1_type_q][s1_bin]);
        end

        // Return reads the old start; a same-cycle launch then installs the new one
        if (ret_hit) begin
            if (valid_q[ret_idx]) begin
                valid_d[ret_idx] = 1'b0;
                s1_v_d           = 1'b1;
                s1_type_d        = bus.ret_type_i;
                s1_lat_d         = global_ctr_i - start_q[ret_idx];
            end else begin
                orphan_d[bus.ret_type_i] = sat_inc(orphan_q[bus.ret_type_i]);
            end
        end

        if (launch_hit) begin
            if (valid_q[launch_idx] && !(ret_hit && (ret_idx == launch_idx)))
                ovw_d[bus.launch_type_i] = sat_inc(ovw_q[bus.launch_type_i]);
            valid_d[launch_idx] = 1'b1;
            start_d[launch_idx] = global_ctr_i;
        end

        if (clear_i) begin
            valid_d   = '0;
            s1_v_d    = 1'b0;
            s1_type_d = '0;
            s1_lat_d  = '0;
            for (int t = 0; t < int'(num_types_lp); t++) begin
                count_d[t]  = '0;
                sum_d[t]    = '0;
                max_d[t]    = '0;
                orphan_d[t] = '0;
                ovw_d[t]    = '0;
                for (int b = 0; b < int'(hist_bins_p); b++) hist_d[t][b] = '0;
            end
        end
    end

    // Read mux works on current state, so reads see pre-update / pre-clear values
    always_comb begin
        rd_v_d      = bus.rd_v_i;
        rd_data_d   = '0;
        outstanding = '0;
        rd_bin      = bin_w_lp'(bus.rd_field_i - 5'd8);

        case (bus.rd_type_i)
            2'd0: for (int i = 0; i < int'(reg_els_p); i++)
                      outstanding = outstanding + ctr_width_p'(valid_q[i]);
            2'd1: for (int i = 0; i < int'(reg_els_p); i++)
                      outstanding = outstanding + ctr_width_p'(valid_q[int'(reg_els_p) + i]);
            2'd2: outstanding = ctr_width_p'(valid_q[num_ent_lp-1]);
            default: outstanding = '0;
        endcase

        if (bus.rd_v_i && (bus.rd_type_i != 2'd3)) begin
            case (bus.rd_field_i)
                5'd0: rd_data_d = sum_width_p'(count_q[bus.rd_type_i]);
                5'd1: rd_data_d = sum_q[bus.rd_type_i];
                5'd2: rd_data_d = sum_width_p'(max_q[bus.rd_type_i]);
                5'd3: rd_data_d = sum_width_p'(outstanding);
                5'd4: rd_data_d = sum_width_p'(orphan_q[bus.rd_type_i]);
                5'd5: rd_data_d = sum_width_p'(ovw_q[bus.rd_type_i]);
                default: begin
                    if ((bus.rd_field_i >= 5'd8) &&
                        (32'(bus.rd_field_i) < 32'(8 + hist_bins_p)))
                        rd_data_d = sum_width_p'(hist_q[bus.rd_type_i][rd_bin]);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q   <= '0;
            s1_v_q    <= 1'b0;
            s1_type_q <= '0;
            s1_lat_q  <= '0;
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
            for (int e = 0; e < int'(num_ent_lp); e++) start_q[e] <= '0;
            for (int t = 0; t < int'(num_types_lp); t++) begin
                count_q[t]  <= '0;
                sum_q[t]    <= '0;
                max_q[t]    <= '0;
                orphan_q[t] <= '0;
                ovw_q[t]    <= '0;
                for (int b = 0; b < int'(hist_bins_p); b++) hist_q[t][b] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            start_q   <= start_d;
            s1_v_q    <= s1_v_d;
            s1_type_q <= s1_type_d;
            s1_lat_q  <= s1_lat_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            orphan_q  <= orphan_d;
            ovw_q     <= ovw_d;
            hist_q    <= hist_d;
            rd_v_q    <= rd_v_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_v_o    = rd_v_q;
    assign bus.rd_data_o = rd_data_q;

endmodule

// File: tb/tb_remote_load_latency_stats.sv
// Randomized + directed bench for remote_load_latency_stats against a behavioural stats model.
module tb_remote_load_latency_stats;
    localparam int REG_ELS = 32;
    localparam int SUM_W   = 33;
    localparam int BINS    = 8;
    localparam longint unsigned CTR_MAX = 64'hFFFF_FFFF;
    localparam longint unsigned SUM_MAX = (64'd1 << SUM_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] ctr = 32'd0;

    remote_load_latency_stats_if #(.reg_els_p(REG_ELS), .sum_width_p(SUM_W)) bif ();

    remote_load_latency_stats #(
        .reg_els_p(REG_ELS), .ctr_width_p(32), .sum_width_p(SUM_W), .hist_bins_p(BINS)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clr),
        .global_ctr_i(ctr), .bus(bif.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending loads per (type, reg) plus plain-arithmetic statistics
    typedef struct { int t; logic [31:0] lat; } upd_t;
    upd_t             upd_q[$];
    bit               m_valid [3][REG_ELS];
    logic [31:0]      m_start [3][REG_ELS];
    longint unsigned  m_count[3], m_sum[3], m_max[3], m_orphan[3], m_ovw[3];
    longint unsigned  m_hist[3][BINS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_zero();
        upd_q.delete();
        for (int t = 0; t < 3; t++) begin
            m_count[t] = 0; m_sum[t] = 0; m_max[t] = 0; m_orphan[t] = 0; m_ovw[t] = 0;
            for (int b = 0; b < BINS; b++) m_hist[t][b] = 0;
            for (int r = 0; r < REG_ELS; r++) begin m_valid[t][r] = 0; m_start[t][r] = 0; end
        end
    endfunction

    function automatic int floor_log2(input longint unsigned v);
        int b = 0;
        while (v > 1) begin v = v >> 1; b++; end
        return b;
    endfunction

    function automatic void model_apply(input int t, input logic [31:0] lat);
        int b;
        m_count[t] = sat(m_count[t] + 1, CTR_MAX);
        m_sum[t]   = sat(m_sum[t] + longint'(lat), SUM_MAX);
        if (longint'(lat) > m_max[t]) m_max[t] = longint'(lat);
        b = floor_log2(longint'(lat));
        if (b > BINS - 1) b = BINS - 1;
        m_hist[t][b] = sat(m_hist[t][b] + 1, CTR_MAX);
    endfunction

    function automatic void model_update();
        int lt, lr, rt, rr;
        bit l_hit, r_hit, l_old;
        logic [31:0] lat;
        if (clr) begin model_zero(); return; end
        foreach (upd_q[i]) model_apply(upd_q[i].t, upd_q[i].lat);
        upd_q.delete();
        l_hit = en && bif.launch_v_i && (bif.launch_type_i != 2'd3);
        r_hit = en && bif.ret_v_i && (bif.ret_type_i != 2'd3);
        lt = int'(bif.launch_type_i); lr = (lt == 2) ? 0 : int'(bif.launch_reg_id_i);
        rt = int'(bif.ret_type_i);    rr = (rt == 2) ? 0 : int'(bif.ret_reg_id_i);
        l_old = l_hit ? m_valid[lt][lr] : 1'b0;
        if (r_hit) begin
            if (m_valid[rt][rr]) begin
                lat = ctr - m_start[rt][rr];
                m_valid[rt][rr] = 0;
                upd_q.push_back('{rt, lat});
            end else begin
                m_orphan[rt] = sat(m_orphan[rt] + 1, CTR_MAX);
            end
        end
        if (l_hit) begin
            if (l_old && !(r_hit && rt == lt && rr == lr)) m_ovw[lt] = sat(m_ovw[lt] + 1, CTR_MAX);
            m_valid[lt][lr] = 1;
            m_start[lt][lr] = ctr;
        end
    endfunction

    function automatic longint unsigned model_read(input int t, input int f);
        longint unsigned n = 0;
        if (t == 3) return 0;
        case (f)
            0: return m_count[t];
            1: return m_sum[t];
            2: return m_max[t];
            3: begin
                for (int r = 0; r < REG_ELS; r++) n += longint'(m_valid[t][r]);
                return n;
            end
            4: return m_orphan[t];
            5: return m_ovw[t];
            default: return (f >= 8 && f < 8 + BINS) ? m_hist[t][f-8] : 0;
        endcase
    endfunction

    task automatic idle_inputs();
        bif.launch_v_i = 1'b0;
        bif.ret_v_i    = 1'b0;
        bif.rd_v_i     = 1'b0;
        clr            = 1'b0;
    endtask

    task automatic launch(input int t, input int r);
        bif.launch_v_i = 1'b1; bif.launch_type_i = 2'(t); bif.launch_reg_id_i = 5'(r);
    endtask

    task automatic ret(input int t, input int r);
        bif.ret_v_i = 1'b1; bif.ret_type_i = 2'(t); bif.ret_reg_id_i = 5'(r);
    endtask

    task automatic rd(input int t, input int f);
        bif.rd_v_i = 1'b1; bif.rd_type_i = 2'(t); bif.rd_field_i = 5'(f);
    endtask

    // One clock: predict the read, let the edge happen, advance the model, compare
    task automatic step();
        logic        exp_v;
        logic [63:0] exp_d;
        string       tag;
        exp_v = bif.rd_v_i;
        exp_d = exp_v ? model_read(int'(bif.rd_type_i), int'(bif.rd_field_i)) : 64'd0;
        tag   = $sformatf("rd t%0d f%0d", bif.rd_type_i, bif.rd_field_i);
        @(posedge clk);
        model_update();
        #1;
        check("rd_v", 64'(bif.rd_v_o), 64'(exp_v));
        if (exp_v) check(tag, 64'(bif.rd_data_o), exp_d);
        idle_inputs();
        ctr = ctr + 32'd1;
    endtask

    task automatic read_expect(input int t, input int f, input logic [63:0] val);
        rd(t, f);
        step();
        check($sformatf("exp t%0d f%0d", t, f), 64'(bif.rd_data_o), val);
    endtask

    initial begin
        bif.launch_type_i = '0; bif.launch_reg_id_i = '0;
        bif.ret_type_i = '0;    bif.ret_reg_id_i = '0;
        bif.rd_type_i = '0;     bif.rd_field_i = '0;
        idle_inputs();
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_v", 64'(bif.rd_v_o), 64'd0);
        check("reset rd_data", 64'(bif.rd_data_o), 64'd0);
        rst_n = 1'b1;
        read_expect(0, 0, 0);

        // Basic int latency
        ctr = 32'd100; launch(0, 5); step();
        ctr = 32'd137; ret(0, 5);    step();
        step();
        read_expect(0, 0, 1);
        read_expect(0, 1, 37);
        read_expect(0, 2, 37);
        read_expect(0, 3, 0);
        read_expect(0, 13, 1);

        // Counter wrap
        ctr = 32'hFFFF_FFF0; launch(1, 2); step();
        ctr = 32'h0000_0010; ret(1, 2);    step();
        step();
        read_expect(1, 2, 32);
        read_expect(1, 13, 1);

        // Orphan and overwrite
        ret(2, 0); step();
        read_expect(2, 4, 1);
        read_expect(2, 0, 0);
        launch(0, 3); step();
        launch(0, 3); step();
        read_expect(0, 5, 1);
        read_expect(0, 3, 1);

        // Same-cycle return and relaunch
        clr = 1'b1; step();
        ctr = 32'd10; launch(0, 7); step();
        ctr = 32'd20; ret(0, 7); launch(0, 7); step();
        ctr = 32'd50; ret(0, 7); step();
        step();
        read_expect(0, 0, 2);
        read_expect(0, 1, 40);
        read_expect(0, 2, 30);
        read_expect(0, 3, 0);
        read_expect(0, 5, 0);

        // Clear with simultaneous return and read
        launch(0, 1); step();
        clr = 1'b1; ret(0, 1); read_expect(0, 0, 2);
        read_expect(0, 0, 0);
        read_expect(0, 3, 0);
        read_expect(0, 0, 0);

        // en_i low ignores events but lets stage 1 finish
        en = 1'b0; launch(0, 4); step();
        read_expect(0, 3, 0);
        en = 1'b1; launch(0, 4); step();
        ret(0, 4); step();
        en = 1'b0; step();
        read_expect(0, 0, 1);
        en = 1'b1;

        // Sum saturation at 2^33-1
        clr = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            ctr = 32'd0;         launch(1, 0); step();
            ctr = 32'hFFFF_FFFF; ret(1, 0);    step();
            step();
            if (i == 1) read_expect(1, 1, 64'h1_FFFF_FFFE);
        end
        read_expect(1, 0, 4);
        read_expect(1, 1, SUM_MAX);
        read_expect(1, 2, 64'hFFFF_FFFF);
        read_expect(1, 15, 4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 1) == 1)
                launch(int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1)
                ret(int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) rd(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 149) == 0) clr = 1'b1;
            if ($urandom_range(0, 99) == 0) ctr = $urandom;
            step();
        end
        en = 1'b1;

        // Asynchronous reset mid-run
        launch(0, 2); rd(0, 0); step();
        rst_n = 1'b0;
        #1;
        check("midrst rd_v", 64'(bif.rd_v_o), 64'd0);
        check("midrst rd_data", 64'(bif.rd_data_o), 64'd0);
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            read_expect(t, 0, 0);
            read_expect(t, 1, 0);
            read_expect(t, 3, 0);
            read_expect(t, 13, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
